circular_convolver: RTL

CIRCULAR_CONVOLVER -- requirements
Module: circular_convolver

---
 rtl/circular_convolver.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/circular_convolver.sv
// circular_convolver
//   Computes the circular convolution y[n] = sum_k x[k] * h[(n-k) mod WIDTH]
//   and emits one exact signed result element per clock cycle. A new input
//   vector is accepted from IDLE, or on the final element of the vector in
//   progress so that consecutive results stream out with no gaps.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   kernel_valid    load kernel_data into the kernel shadow register
//   kernel_data     kernel vector h, element k at [k]
//   parallel_valid  single-cycle pulse, parallel_data holds vector x
//   parallel_data   input vector x, element k at [k]
//   out_valid       out_data holds y[out_index]
//   out_data        signed result element (OLEN bits)
//   out_index       result index n
//   out_last        out_valid on the final element (index WIDTH-1)
//   busy            a vector is being processed
//   overflow        sticky: an input vector arrived while busy and was dropped
module circular_convolver #(
  parameter int XLEN  = 8,
  parameter int WIDTH = 16,
  parameter int OLEN  = 2*XLEN + $clog2(WIDTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            kernel_valid,
  input  logic [WIDTH-1:0][XLEN-1:0]      kernel_data,
  input  logic                            parallel_valid,
  input  logic [WIDTH-1:0][XLEN-1:0]      parallel_data,
  output logic                            out_valid,
  output logic [OLEN-1:0]                 out_data,
  output logic [$clog2(WIDTH)-1:0]        out_index,
  output logic                            out_last,
  output logic                            busy,
  output logic                            overflow
);

  localparam int NW = $clog2(WIDTH);
  localparam logic [NW-1:0] LAST = NW'(WIDTH-1);

  typedef enum logic {IDLE, COMPUTE} state_t;

  state_t                      state_q, state_d;
  logic [NW-1:0]               n_q, n_d;
  logic [WIDTH-1:0][XLEN-1:0]  x_q;
  logic [WIDTH-1:0][XLEN-1:0]  h_sh_q;
  logic [WIDTH-1:0][XLEN-1:0]  h_act_q;
  logic                        accept;
  logic                        drop;

  logic                        out_valid_q;
  logic                        out_last_q;
  logic [OLEN-1:0]             out_data_q;
  logic [NW-1:0]               out_index_q;
  logic                        overflow_q;

  logic signed [OLEN-1:0]      acc;
  logic signed [2*XLEN-1:0]    prod;
  logic [NW-1:0]               hidx;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (parallel_valid) state_d = COMPUTE;
      COMPUTE: if (n_q == LAST && !parallel_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: accepting on the last element keeps the stream contiguous
  always_comb begin
    busy   = (state_q == COMPUTE);
    accept = parallel_valid && (state_q == IDLE || n_q == LAST);
    drop   = parallel_valid && !accept;
  end

  always_comb begin
    if (accept)                    n_d = '0;
    else if (busy && n_q != LAST)  n_d = n_q + 1'b1;
    else                           n_d = '0;
  end

  // Element n of the circular convolution; kernel index wraps without a
  // modulo so non-power-of-two WIDTH stays cheap.
  always_comb begin
    acc  = '0;
    prod = '0;
    hidx = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      if (n_q >= NW'(k)) hidx = n_q - NW'(k);
      else               hidx = n_q + NW'(WIDTH - k);
      prod = $signed(x_q[k]) * $signed(h_act_q[hidx]);
      acc  = acc + OLEN'(prod);
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q         <= '0;
      x_q         <= '0;
      h_sh_q      <= '0;
      h_act_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      n_q <= n_d;
      if (kernel_valid) h_sh_q <= kernel_data;
      if (accept) begin
        x_q     <= parallel_data;
        // same-cycle kernel load bypasses the shadow
        h_act_q <= kernel_valid ? kernel_data : h_sh_q;
      end
      if (drop) overflow_q <= 1'b1;
      out_valid_q <= busy;
      out_last_q  <= busy && (n_q == LAST);
      if (busy) begin
        out_data_q  <= acc;
        out_index_q <= n_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign overflow  = overflow_q;

endmodule
